// File: rtl/pi_switch_sched_pkg.sv
// Shared constants and state type for the pi switch output scheduler.
package pi_switch_sched_pkg;

  localparam int PI_LR_N   = 6;
  localparam int PI_UU_N   = 4;
  localparam int PI_LR_S_W = 3;
  localparam int PI_UU_S_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } pi_sched_state_t;

endpackage

// File: rtl/pi_switch_sched_rr_chan.sv
// One output channel: arbitrates N requesters, holds the mux select and
// valid until downstream accepts, and pulses a one-hot grant on transfer.
module pi_rr_chan
  import pi_switch_sched_pkg::*;
#(
  parameter int N     = PI_LR_N,
  parameter bit RR_EN = 1'b1,
  parameter int S_W   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_i,
  input  logic           ready_i,
  output logic [N-1:0]   gnt_o,
  output logic [S_W-1:0] s_o,
  output logic           valid_o
);

  localparam int IW = S_W + 1;

  pi_sched_state_t state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [S_W-1:0]  ptr_q, ptr_d;
  logic [S_W-1:0]  ptr_nxt_s, start_s, win_s;
  logic [N-1:0]    sel_oh_s, cand_s, gnt_s;
  logic [IW-1:0]   idx_s;
  logic            found_s;

  assign sel_oh_s  = {{(N-1){1'b0}}, 1'b1} << s_q;
  assign ptr_nxt_s = (s_q == S_W'(N - 1)) ? '0 : s_q + S_W'(1);

  // The current winner is masked on its own transfer cycle, so a lone
  // requester sees a one-cycle bubble between consecutive flits.
  always_comb begin
    cand_s  = (state_q == BUSY) ? (req_i & ~sel_oh_s) : req_i;
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    if (RR_EN) begin
      start_s = (state_q == BUSY) ? ptr_nxt_s : ptr_q;
    end else begin
      start_s = '0;
    end
    for (int i = 0; i < N; i++) begin
      idx_s = {1'b0, start_s} + IW'(i);
      if (idx_s >= IW'(N)) begin
        idx_s = idx_s - IW'(N);
      end
      if (!found_s && cand_s[idx_s[S_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[S_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    gnt_s   = '0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = BUSY;
          s_d     = win_s;
        end
      end
      BUSY: begin
        if (ready_i) begin
          gnt_s = sel_oh_s;
          ptr_d = ptr_nxt_s;
          if (found_s) begin
            s_d = win_s;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt_o   = gnt_s;
  assign s_o     = s_q;
  assign valid_o = (state_q == BUSY);

endmodule

// File: rtl/pi_switch_sched.sv
// Pi switch output scheduler: two 6-way left/right channels and two 4-way
// up channels, each an independent arbiter with valid/ready toward its link.
module pi_switch_sched
  import pi_switch_sched_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0][PI_LR_N-1:0]        lr_req,
  output logic [1:0][PI_LR_N-1:0]        lr_gnt,
  output logic [1:0][PI_LR_S_W-1:0]      lr_s,
  output logic [1:0]                     lr_o_valid,
  input  logic [1:0]                     lr_o_ready,
  input  logic [1:0][PI_UU_N-1:0]        u0u1_req,
  output logic [1:0][PI_UU_N-1:0]        u0u1_gnt,
  output logic [1:0][PI_UU_S_W-1:0]      u0u1_s,
  output logic [1:0]                     u0u1_o_valid,
  input  logic [1:0]                     u0u1_o_ready
);

  for (genvar c = 0; c < 2; c++) begin : g_ch
    pi_rr_chan #(
      .N    (PI_LR_N),
      .RR_EN(RR_EN),
      .S_W  (PI_LR_S_W)
    ) u_lr (
      .clk    (clk),
      .rst    (rst),
      .req_i  (lr_req[c]),
      .ready_i(lr_o_ready[c]),
      .gnt_o  (lr_gnt[c]),
      .s_o    (lr_s[c]),
      .valid_o(lr_o_valid[c])
    );

    pi_rr_chan #(
      .N    (PI_UU_N),
      .RR_EN(RR_EN),
      .S_W  (PI_UU_S_W)
    ) u_uu (
      .clk    (clk),
      .rst    (rst),
      .req_i  (u0u1_req[c]),
      .ready_i(u0u1_o_ready[c]),
      .gnt_o  (u0u1_gnt[c]),
      .s_o    (u0u1_s[c]),
      .valid_o(u0u1_o_valid[c])
    );
  end

endmodule
